// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pwm_seq_pkg : shared state encoding, field widths and duty clamp helper    |
// | Revision    : 1.0                                                         |
// +---------------------------------------------------------------------------+
package pwm_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int PERIOD_W  = 16;
  localparam int DUTY_W    = 8;
  localparam int RPT_W_DEF = 8;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd100;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_seq_table.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pwm_seq_table : step table, one write port (duty clamped), async read     |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module pwm_seq_table
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [PERIOD_W-1:0] wperiod,
  input  logic [DUTY_W-1:0]   wduty,
  input  logic [RPT_W-1:0]    wrpt,
  input  logic [AW-1:0]       raddr,
  output logic [PERIOD_W-1:0] rperiod,
  output logic [DUTY_W-1:0]   rduty,
  output logic [RPT_W-1:0]    rrpt
);

  logic [PERIOD_W-1:0] period_q [DEPTH];
  logic [DUTY_W-1:0]   duty_q   [DEPTH];
  logic [RPT_W-1:0]    rpt_q    [DEPTH];

  // Contents deliberately survive reset so software need not reprogram.
  always_ff @(posedge clk) begin
    if (we) begin
      period_q[waddr] <= wperiod;
      duty_q[waddr]   <= clamp_duty(wduty);
      rpt_q[waddr]    <= wrpt;
    end
  end

  assign rperiod = period_q[raddr];
  assign rduty   = duty_q[raddr];
  assign rrpt    = rpt_q[raddr];

endmodule
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pwm_sequencer : steps a pwm through a (period, duty, repeat) table        |
// | Optional macro SEQ_RAMP_EN: duty ramps by 1 per period toward target      |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfgWe,
  input  logic [AW-1:0]       cfgAddr,
  input  logic [PERIOD_W-1:0] cfgPeriod,
  input  logic [DUTY_W-1:0]   cfgDuty,
  input  logic [RPT_W-1:0]    cfgRepeat,
  input  logic [AW:0]         seqLen,
  input  logic                loopEn,
  input  logic                start,
  input  logic                abort,
  input  logic                periodEnd,
  output logic [PERIOD_W-1:0] pwmPeriod,
  output logic [DUTY_W-1:0]   pwmDuty,
  output logic                pwmEn,
  output logic [AW-1:0]       stepIdx,
  output logic                busy,
  output logic                done
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [1:0]          state_q,  state_d;
  logic [AW-1:0]       step_q,   step_d;
  logic [AW:0]         len_q,    len_d;
  logic                loop_q,   loop_d;
  logic [RPT_W-1:0]    cnt_q,    cnt_d;
  logic [RPT_W-1:0]    tgt_q,    tgt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUTY_W-1:0]   duty_q,   duty_d;
  logic                en_q,     en_d;
`ifdef SEQ_RAMP_EN
  logic [DUTY_W-1:0]   dtgt_q,   dtgt_d;
`endif

  logic [PERIOD_W-1:0] rd_period;
  logic [DUTY_W-1:0]   rd_duty;
  logic [RPT_W-1:0]    rd_rpt;
  logic                last_step;

  pwm_seq_table #(.DEPTH(DEPTH), .AW(AW), .RPT_W(RPT_W)) u_table (
    .clk     (clk),
    .we      (cfgWe && (state_q == S_IDLE)),
    .waddr   (cfgAddr),
    .wperiod (cfgPeriod),
    .wduty   (cfgDuty),
    .wrpt    (cfgRepeat),
    .raddr   (step_q),
    .rperiod (rd_period),
    .rduty   (rd_duty),
    .rrpt    (rd_rpt)
  );

  assign last_step = ({1'b0, step_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    loop_d   = loop_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    period_d = period_q;
    duty_d   = duty_q;
    en_d     = en_q;
`ifdef SEQ_RAMP_EN
    dtgt_d   = dtgt_q;
`endif
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (seqLen != '0)) begin
            len_d   = (seqLen > DEPTH_L) ? DEPTH_L : seqLen;
            loop_d  = loopEn;
            step_d  = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          period_d = rd_period;
`ifdef SEQ_RAMP_EN
          dtgt_d   = rd_duty;
`else
          duty_d   = rd_duty;
`endif
          tgt_d    = (rd_rpt == '0) ? RPT_W'(1) : rd_rpt;
          cnt_d    = '0;
          en_d     = 1'b1;
          state_d  = S_RUN;
        end
        S_RUN: begin
          if (periodEnd) begin
`ifdef SEQ_RAMP_EN
            if (duty_q < dtgt_q)      duty_d = duty_q + DUTY_W'(1);
            else if (duty_q > dtgt_q) duty_d = duty_q - DUTY_W'(1);
`endif
            if (cnt_q == (tgt_q - RPT_W'(1))) begin
              cnt_d = '0;
              if (!last_step) begin
                step_d  = step_q + AW'(1);
                state_d = S_LOAD;
              end else if (loop_q) begin
                step_d  = '0;
                state_d = S_LOAD;
              end else begin
                en_d    = 1'b0;
                state_d = S_DONE;
              end
            end else begin
              cnt_d = cnt_q + RPT_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      tgt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      en_q     <= 1'b0;
`ifdef SEQ_RAMP_EN
      dtgt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      en_q     <= en_d;
`ifdef SEQ_RAMP_EN
      dtgt_q   <= dtgt_d;
`endif
    end
  end

  assign pwmPeriod = period_q;
  assign pwmDuty   = duty_q;
  assign pwmEn     = en_q;
  assign stepIdx   = step_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pwm_sequencer : directed self-checking bench for pwm_sequencer         |
// | Revision         : 1.0                                                    |
// +---------------------------------------------------------------------------+
module tb_pwm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfgWe;
  logic [2:0]  cfgAddr;
  logic [15:0] cfgPeriod;
  logic [7:0]  cfgDuty;
  logic [7:0]  cfgRepeat;
  logic [3:0]  seqLen;
  logic        loopEn;
  logic        start;
  logic        abort;
  logic        periodEnd;
  logic [15:0] pwmPeriod;
  logic [7:0]  pwmDuty;
  logic        pwmEn;
  logic [2:0]  stepIdx;
  logic        busy;
  logic        done;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int exp_idx [10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};

  pwm_sequencer #(.DEPTH(8), .AW(3), .RPT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfgWe     (cfgWe),
    .cfgAddr   (cfgAddr),
    .cfgPeriod (cfgPeriod),
    .cfgDuty   (cfgDuty),
    .cfgRepeat (cfgRepeat),
    .seqLen    (seqLen),
    .loopEn    (loopEn),
    .start     (start),
    .abort     (abort),
    .periodEnd (periodEnd),
    .pwmPeriod (pwmPeriod),
    .pwmDuty   (pwmDuty),
    .pwmEn     (pwmEn),
    .stepIdx   (stepIdx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic pe();
    periodEnd = 1'b1;
    tick();
    periodEnd = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] p, input logic [7:0] d,
                    input logic [7:0] r);
    cfgWe = 1'b1; cfgAddr = a; cfgPeriod = p; cfgDuty = d; cfgRepeat = r;
    tick();
    cfgWe = 1'b0;
  endtask

  task automatic go(input logic [3:0] len, input logic lp);
    seqLen = len; loopEn = lp; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgPeriod = '0; cfgDuty = '0;
    cfgRepeat = '0; seqLen = '0; loopEn = 1'b0; start = 1'b1; abort = 1'b0;
    periodEnd = 1'b0;

    // Reset held with start asserted
    repeat (3) tick();
    check("rst_period", pwmPeriod, 0);
    check("rst_duty",   pwmDuty,   0);
    check("rst_en",     pwmEn,     0);
    check("rst_step",   stepIdx,   0);
    check("rst_busy",   busy,      0);
    check("rst_done",   done,      0);
    start = 1'b0; rst = 1'b1;
    tick();

    // One-shot run
    wr(3'd0, 16'd1000, 8'd25, 8'd2);
    wr(3'd1, 16'd500,  8'd75, 8'd3);
    seqLen = 4'd2; loopEn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("os_busy_rise", busy, 1);
    tick();
    check("os_period0", pwmPeriod, 1000);
    check("os_duty0",   pwmDuty,   25);
    check("os_en0",     pwmEn,     1);
    pe(); pe();
    check("os_period1", pwmPeriod, 500);
    check("os_duty1",   pwmDuty,   75);
    check("os_step1",   stepIdx,   1);
    done_cnt = 0;
    pe(); pe(); pe();
    check("os_done_cnt", done_cnt, 1);
    check("os_en_off",   pwmEn,    0);
    check("os_busy_off", busy,     0);
    check("os_hold_per", pwmPeriod, 500);
    check("os_hold_dut", pwmDuty,   75);

    // Looping run
    done_cnt = 0;
    go(4'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("loop_idx%0d", i), stepIdx, exp_idx[i]);
      pe();
    end
    check("loop_no_done", done_cnt, 0);
    check("loop_busy",    busy,     1);

    // Abort coincident with periodEnd in step 1
    pe(); pe();
    check("ab_pre_step", stepIdx, 1);
    abort = 1'b1; periodEnd = 1'b1;
    tick();
    abort = 1'b0; periodEnd = 1'b0;
    check("ab_busy", busy,    0);
    check("ab_en",   pwmEn,   0);
    check("ab_step", stepIdx, 1);
    tick(); tick();
    check("ab_no_done", done_cnt, 0);
    check("ab_idle",    busy,     0);

    // seqLen of zero ignores start
    seqLen = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_busy_a", busy, 0);
    tick();
    check("len0_busy_b", busy, 0);
    check("len0_done",   done_cnt, 0);

    // Duty clamp and zero repeat
    wr(3'd0, 16'd300, 8'd150, 8'd0);
    wr(3'd1, 16'd700, 8'd40,  8'd1);
    go(4'd2, 1'b0);
    check("clamp_duty",  pwmDuty,   100);
    check("clamp_per",   pwmPeriod, 300);
    pe();
    check("rpt0_step",   stepIdx,   1);
    check("rpt0_per",    pwmPeriod, 700);
    check("rpt0_duty",   pwmDuty,   40);
    pe();
    check("rpt0_done",   done_cnt,  1);

    // Table write while busy is dropped
    go(4'd2, 1'b0);
    wr(3'd0, 16'd999, 8'd5, 8'd4);
    check("wb_busy", busy, 1);
    pe(); pe();
    check("wb_done", done_cnt, 2);
    go(4'd2, 1'b0);
    check("wb_per",  pwmPeriod, 300);
    check("wb_duty", pwmDuty,   100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wb_abort_idle", busy, 0);

`ifdef SEQ_RAMP_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wr(3'd0, 16'd1000, 8'd10, 8'd12);
    wr(3'd1, 16'd1000, 8'd14, 8'd8);
    go(4'd2, 1'b0);
    check("ramp_start", pwmDuty, 0);
    repeat (12) pe();
    check("ramp_step1", stepIdx, 1);
    check("ramp_base",  pwmDuty, 10);
    for (int k = 1; k <= 6; k++) begin
      pe();
      check($sformatf("ramp_%0d", k), pwmDuty, (k < 4) ? 10 + k : 14);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
